// File: rtl/display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_pkg: shared types and constants for the 4-digit scanner  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package display_pkg;

  localparam logic [0:0] c_ST_BLANK = 1'b0;
  localparam logic [0:0] c_ST_ON    = 1'b1;

  typedef logic [1:0] digit_idx_t;

  function automatic int unsigned slot_cycles(input int unsigned clk_hz, input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Guard against a 1-cycle slot collapsing the prescaler to zero width.
  function automatic int unsigned presc_width(input int unsigned slot);
    return (slot < 2) ? 1 : $clog2(slot);
  endfunction

  localparam int unsigned c_CLK_HZ_DEF  = 50_000_000;
  localparam int unsigned c_SCAN_HZ_DEF = 1000;
  localparam int unsigned SLOT          = slot_cycles(c_CLK_HZ_DEF, c_SCAN_HZ_DEF);
  localparam int unsigned PRESC_W       = presc_width(SLOT);

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scan_prescaler: counts 0..SLOT-1 and flags the last count (wrap) |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module scan_prescaler #(
  parameter int unsigned SLOT    = 10,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PRESC_W-1:0] o_count,
  output logic               o_wrap
);

  localparam logic [PRESC_W-1:0] c_LAST = PRESC_W'(SLOT - 1);

  logic [PRESC_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/display_scan_4digit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_scan_4digit: multiplexed 4-digit common-anode scanner    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module display_scan_4digit
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk50MHz,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  bcd_out,
  output logic        dp_out,
  output logic [3:0]  digit_sel_n,
  output logic        frame_start
);

  localparam int unsigned       c_SLOT       = slot_cycles(CLK_HZ, SCAN_HZ);
  localparam int unsigned       c_PW         = presc_width(c_SLOT);
  localparam logic [c_PW-1:0]   c_BLANK_LAST = c_PW'(BLANK_CYCLES - 1);

  logic [c_PW-1:0] w_count;
  logic            w_wrap;
  logic            w_frame_tick;
  logic [3:0]      w_supp;

  logic [0:0]      r_state;
  digit_idx_t      r_index;
  logic [15:0]     r_snap_bcd;
  logic [3:0]      r_snap_dp;
  logic            r_snap_lz;

  scan_prescaler #(
    .SLOT    (c_SLOT),
    .PRESC_W (c_PW)
  ) u_prescaler (
    .clk     (clk50MHz),
    .rst_n   (rst_n),
    .o_count (w_count),
    .o_wrap  (w_wrap)
  );

  assign w_frame_tick = (r_index == 2'd0) && (w_count == '0);

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_BLANK;
      r_index    <= '0;
      r_snap_bcd <= '0;
      r_snap_dp  <= '0;
      r_snap_lz  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_BLANK: if (w_count == c_BLANK_LAST) r_state <= c_ST_ON;
        default:    if (w_wrap) r_state <= c_ST_BLANK;
      endcase
      if (w_wrap) begin
        r_index <= r_index + 2'd1;
      end
      if (w_frame_tick) begin
        r_snap_bcd <= bcd_in;
        r_snap_dp  <= dp_in;
        r_snap_lz  <= lz_en;
      end
    end
  end

  // A digit goes dark when it and every digit to its left are zero with no dp.
  assign w_supp[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_supp
    assign w_supp[gi] = r_snap_lz && ~|r_snap_bcd[15:4*gi] && ~r_snap_dp[gi];
  end

  assign bcd_out     = r_snap_bcd[{r_index, 2'b00} +: 4];
  assign dp_out      = r_snap_dp[r_index];
  assign digit_sel_n = ((r_state == c_ST_ON) && !w_supp[r_index]) ? ~(4'b0001 << r_index) : 4'b1111;
  // Gated by rst_n so the pulse is absent while reset is held.
  assign frame_start = rst_n & w_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_4digit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_display_scan_4digit: directed + random bench for the scanner  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_display_scan_4digit;

  logic        clk50MHz = 1'b0;
  logic        rst_n    = 1'b0;
  logic [15:0] bcd_in   = '0;
  logic [3:0]  dp_in    = '0;
  logic        lz_en    = 1'b0;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic [3:0]  digit_sel_n;
  logic        frame_start;

  int compared   = 0;
  int mismatched = 0;
  int cur        = 0;

  display_scan_4digit #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2)
  ) dut (
    .clk50MHz    (clk50MHz),
    .rst_n       (rst_n),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .lz_en       (lz_en),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .digit_sel_n (digit_sel_n),
    .frame_start (frame_start)
  );

  always #5 clk50MHz = ~clk50MHz;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        lz;
    int          cyc;
    logic [3:0]  sel;
    logic        fs;
    logic [3:0]  bo;
    logic        dpo;
    logic        chk_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur);
    end
  endtask

  // Release at a falling edge; cycle 0 is the period before the next rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk50MHz);
    @(negedge clk50MHz);
    rst_n = 1'b1;
    #1;
    cur = 0;
  endtask

  task automatic step();
    @(negedge clk50MHz);
    #1;
    cur++;
  endtask

  task automatic goto(input int target);
    while (cur < target) step();
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h1234, 4'b0100, 1'b0,  0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0,  1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0,  2, 4'hE, 1'b0, 4'h4, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0,  9, 4'hE, 1'b0, 4'h4, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0, 12, 4'hD, 1'b0, 4'h3, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0, 25, 4'hB, 1'b0, 4'h2, 1'b1, 1'b1});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0, 30, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0, 35, 4'h7, 1'b0, 4'h1, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 4'b0100, 1'b0, 40, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{16'h0050, 4'b0000, 1'b1,  5, 4'hE, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0050, 4'b0000, 1'b1, 15, 4'hD, 1'b0, 4'h5, 1'b0, 1'b1});
    vecs.push_back('{16'h0050, 4'b0000, 1'b1, 25, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0050, 4'b0000, 1'b1, 35, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0050, 4'b0000, 1'b0, 35, 4'h7, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 1'b1,  5, 4'hE, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 1'b1, 15, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 1'b1, 25, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 1'b1, 35, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 4'b0100, 1'b1, 15, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 4'b0100, 1'b1, 25, 4'hB, 1'b0, 4'h0, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 4'b0100, 1'b1, 35, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{16'hF0AB, 4'b0000, 1'b0,  5, 4'hE, 1'b0, 4'hB, 1'b0, 1'b1});
    vecs.push_back('{16'hF0AB, 4'b0000, 1'b0, 15, 4'hD, 1'b0, 4'hA, 1'b0, 1'b1});
    vecs.push_back('{16'hF0AB, 4'b0000, 1'b0, 35, 4'h7, 1'b0, 4'hF, 1'b0, 1'b1});

    // Reset state with live nonzero inputs: snapshot must stay cleared.
    bcd_in = 16'h9876; dp_in = 4'hF; lz_en = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk50MHz);
    @(negedge clk50MHz); #1;
    chk("rst_sel", 32'(digit_sel_n), 32'hF);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_dp", 32'(dp_out), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);

    foreach (vecs[k]) begin
      bcd_in = vecs[k].bcd; dp_in = vecs[k].dp; lz_en = vecs[k].lz;
      do_reset();
      goto(vecs[k].cyc);
      chk($sformatf("v%0d_sel", k), 32'(digit_sel_n), 32'(vecs[k].sel));
      chk($sformatf("v%0d_fs", k), 32'(frame_start), 32'(vecs[k].fs));
      if (vecs[k].chk_data) begin
        chk($sformatf("v%0d_bcd", k), 32'(bcd_out), 32'(vecs[k].bo));
        chk($sformatf("v%0d_dp", k), 32'(dp_out), 32'(vecs[k].dpo));
      end
    end

    // No tearing: a change at cycle 15 shows only from the next frame.
    bcd_in = 16'h1111; dp_in = 4'h0; lz_en = 1'b0;
    do_reset();
    for (int c = 1; c < 80; c++) begin
      step();
      if (c == 15) bcd_in = 16'h9999;
      if ((c % 10) != 0) chk("tear_bcd", 32'(bcd_out), (c < 40) ? 32'h1 : 32'h9);
    end

    // Asynchronous reset pulse mid-slot of digit 2.
    bcd_in = 16'h1234; dp_in = 4'b0100; lz_en = 1'b0;
    do_reset();
    goto(25);
    chk("pre_rst_sel", 32'(digit_sel_n), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(digit_sel_n), 32'hF);
    chk("async_rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk50MHz);
    rst_n = 1'b1;
    #1;
    cur = 0;
    chk("restart_fs", 32'(frame_start), 32'h1);
    chk("restart_sel0", 32'(digit_sel_n), 32'hF);
    goto(1);
    chk("restart_sel1", 32'(digit_sel_n), 32'hF);
    goto(2);
    chk("restart_sel2", 32'(digit_sel_n), 32'hE);
    goto(12);
    chk("restart_sel12", 32'(digit_sel_n), 32'hD);

    // Random inputs: at most one digit lit, 40-cycle frame period.
    begin
      int last_fs;
      last_fs = -1;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
        bcd_in = 16'($urandom);
        dp_in  = 4'($urandom);
        lz_en  = 1'($urandom);
        chk("onehot", 32'($countones(~digit_sel_n) <= 1), 32'h1);
        if (frame_start) begin
          if (last_fs >= 0) chk("fs_period", 32'(cur - last_fs), 32'd40);
          last_fs = cur;
        end
        step();
      end
      chk("fs_seen", 32'(last_fs >= 0), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_4digit.md
DISPLAY_SCAN_4DIGIT -- requirements
Module: display_scan_4digit

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, SHALL give the input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, SHALL give the digit-slot rate in Hz; SLOT = CLK_HZ/SCAN_HZ cycles per digit.
REQ-003 Parameter BLANK_CYCLES, default 500, SHALL give the all-digits-off guard at the start of each slot; legal only when 2 <= BLANK_CYCLES <= SLOT-2.
REQ-004 Port clk50MHz, input, 1, SHALL be the single clock, rising-edge.
REQ-005 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-006 Port bcd_in, input, 16, SHALL carry four BCD digits: [3:0] is digit 0 (rightmost) through [15:12] is digit 3.
REQ-007 Port dp_in, input, 4, SHALL carry the per-digit decimal point request (bit i = digit i, active-high).
REQ-008 Port lz_en, input, 1, SHALL enable leading-zero blanking.
REQ-009 Port bcd_out, output, 4, SHALL carry the nibble of the active digit to the downstream BCD-to-7-segment decoder.
REQ-010 Port dp_out, output, 1, SHALL carry the decimal point of the active digit (active-high) to the decoder.
REQ-011 Port digit_sel_n, output, 4, SHALL carry the active-low common-anode digit enables (bit i = digit i).
REQ-012 Port frame_start, output, 1, SHALL give a one-cycle pulse marking the input snapshot.

Function
REQ-013 A prescaler SHALL count 0..SLOT-1 and wrap to 0; the digit index SHALL advance 0->1->2->3->0 on each wrap.
REQ-014 The FSM SHALL have exactly two states.
  - BLANK: prescaler 0..BLANK_CYCLES-1.
  - ON: prescaler BLANK_CYCLES..SLOT-1.
  - BLANK->ON when prescaler = BLANK_CYCLES-1; ON->BLANK on prescaler wrap.
REQ-015 In BLANK, digit_sel_n SHALL be 4'b1111.
REQ-016 In ON, digit_sel_n SHALL drive low only the bit of the current index, unless that digit is suppressed (REQ-020).
REQ-017 frame_start SHALL be high in exactly the cycle where index = 0 and prescaler = 0, and low otherwise.
REQ-018 bcd_in, dp_in and lz_en SHALL be captured into snapshot registers at the clock edge ending the frame_start cycle. Input changes at any other time SHALL NOT alter the displayed frame (no tearing).
REQ-019 bcd_out and dp_out SHALL equal the snapshot nibble and dp bit of the current index from prescaler = 1 onward in every slot. Their values in BLANK are don't-care, except at reset.
REQ-020 Digit i SHALL be suppressed (digit_sel_n[i] stays 1 during ON) when all of the following hold:
  - snapshot lz_en = 1;
  - i != 0;
  - snapshot nibbles i..3 are all zero;
  - snapshot dp bit i = 0.
  Digit 0 SHALL never be suppressed.
REQ-021 Non-BCD nibbles (A-F) SHALL pass to bcd_out unchanged; decoding them is the decoder's job.
REQ-022 All outputs SHALL be registered or decoded only from registered state (Moore); no combinational path from inputs to outputs.
REQ-023 Exactly one digit_sel_n bit at most SHALL be low in any cycle.

Reset
REQ-024 While rst_n = 0, the following SHALL be held at zero: prescaler, index, snapshot registers, bcd_out, dp_out and frame_start. The FSM SHALL be in BLANK and digit_sel_n SHALL be 4'b1111.
REQ-025 The first cycle after rst_n rises SHALL be a frame_start cycle (index 0, prescaler 0).
REQ-026 Reset asserted mid-slot SHALL force all digits off within the same cycle, without waiting for a clock edge.

Structure
REQ-027 A shared package display_pkg SHALL hold the following:
  - FSM state encoding (BLANK, ON);
  - 2-bit digit-index type;
  - derived constant SLOT;
  - prescaler width, $clog2(SLOT).
REQ-028 The prescaler and wrap-tick generation SHALL be one sub-module, scan_prescaler. The FSM, index, snapshot and blanking logic SHALL remain in display_scan_4digit.

Verification
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (SLOT=10) and BLANK_CYCLES=2.
REQ-029 Reset release -> frame_start high in cycle 0; digit_sel_n = 1111 for cycles 0-1; digit_sel_n = 1110 for cycles 2-9; digit_sel_n = 1101 for cycles 12-19.
REQ-030 bcd_in=16'h1234, dp_in=4'b0100, lz_en=0 -> across one 40-cycle frame:
  - digit 0: bcd_out 4, dp_out 0;
  - digit 1: bcd_out 3, dp_out 0;
  - digit 2: bcd_out 2, dp_out 1;
  - digit 3: bcd_out 1, dp_out 0.
REQ-031 bcd_in=16'h0050, lz_en=1, dp_in=0 -> digits 3 and 2 stay off (bits 3,2 of digit_sel_n never 0); digits 1 and 0 lit. bcd_in=16'h0000 -> only digit 0 lit, showing 0.
REQ-032 bcd_in changed from 16'h1111 to 16'h9999 at cycle 15 of a frame -> 1 is displayed through cycle 39; 9 is displayed from the next frame.
REQ-033 rst_n pulsed low for 1 cycle at cycle 25 (digit 2 ON) -> digit_sel_n = 1111 immediately; sequence restarts per REQ-029.
REQ-034 Check over 10 000 random-stimulus cycles -> never more than one digit_sel_n bit low; frame_start period exactly 40 cycles.
